ccu_snoop_fanout: RTL and testbench

Broadcasts one snoop transaction to every cache selected by a domain mask and merges the answers into a single snoop response. The AC request comes from one snoop port of the CCU snoop path, together with its domain mask. The block collects every CR response, merges them into one CR, and forwards exactly one CD data stream back to that path. Unused CD streams from other snoopers are drained. One instance sits on each of the two snoop ports (write path, read path), between the snoop path and the per-cache snoop interfaces.

---
 rtl/ccu_snoop_fanout_pkg.sv | 61 ++++++
 rtl/ccu_snoop_fanout_if.sv | 33 +++
 rtl/ccu_snoop_fanout.sv | 162 ++++++++++++++++
 tb/tb_ccu_snoop_fanout.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_snoop_fanout_pkg.sv
// Types, CR bit positions and FSM encoding shared by the snoop fan-out block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: AC/CR/CD channel types, snoop request/response structs,
//           ccu_snoop_fanout_state_e, lowest_set() data-source picker.
package ccu_snoop_fanout_pkg;

   // crresp bit positions
   localparam int unsigned CrDataTransfer = 0;
   localparam int unsigned CrError        = 1;
   localparam int unsigned CrPassDirty    = 2;
   localparam int unsigned CrIsShared     = 3;
   localparam int unsigned CrWasUnique    = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  snoop;
      logic [2:0]  prot;
   } snoop_ac_t;

   typedef logic [4:0] snoop_cr_t;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } snoop_cd_t;

   typedef struct packed {
      snoop_ac_t ac;
      logic      ac_valid;
      logic      cr_ready;
      logic      cd_ready;
   } snoop_req_t;

   typedef struct packed {
      logic      ac_ready;
      logic      cr_valid;
      snoop_cr_t cr_resp;
      logic      cd_valid;
      snoop_cd_t cd;
   } snoop_resp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNOOP = 2'd1,
      RESP  = 2'd2,
      DATA  = 2'd3
   } ccu_snoop_fanout_state_e;

   // Trailing-zero count: index of the lowest set bit, 0 for an empty vector.
   // Supports up to 32 snooped caches.
   function automatic int unsigned lowest_set(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ccu_snoop_fanout_if.sv
// Bundle of the upstream snoop port, its domain mask and the per-cache snoop ports.
// Latency: n/a (wires only).
// Backpressure: n/a; valid/ready semantics are those of the carried structs.
// Modports: slave  = fan-out block view (upstream req/mask in, per-cache resps in)
//           master = surrounding logic view (drives upstream req/mask and per-cache resps)
interface ccu_snoop_fanout_if #(
   parameter int unsigned NoMstPorts = 2
);
   import ccu_snoop_fanout_pkg::*;

   snoop_req_t                   slv_snoop_req;
   snoop_resp_t                  slv_snoop_resp;
   logic [NoMstPorts-1:0]        slv_mask;
   snoop_req_t  [NoMstPorts-1:0] mst_snoop_reqs;
   snoop_resp_t [NoMstPorts-1:0] mst_snoop_resps;

   modport slave (
      input  slv_snoop_req,
      input  slv_mask,
      input  mst_snoop_resps,
      output slv_snoop_resp,
      output mst_snoop_reqs
   );

   modport master (
      output slv_snoop_req,
      output slv_mask,
      output mst_snoop_resps,
      input  slv_snoop_resp,
      input  mst_snoop_reqs
   );

endinterface

// File: rtl/ccu_snoop_fanout.sv
// Broadcasts one AC to every cache in the domain mask, ORs all CRs into one upstream CR, forwards one CD stream and drains the rest.
// Latency: AC accept c0, downstream AC c1, CR c2, upstream CR c3, first CD beat c4; CD is zero-cycle pass-through.
// Backpressure: one snoop outstanding (ac_ready only in IDLE); stalled caches stall completion; upstream cd_ready throttles the source cache.
// Ports: clk_i, rst_ni (async, active-low); snp.slave carries the upstream
//        request/response, the domain mask and the per-cache request/response arrays.
module ccu_snoop_fanout
   import ccu_snoop_fanout_pkg::*;
#(
   parameter int unsigned NoMstPorts = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   ccu_snoop_fanout_if.slave snp
);

   localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

   typedef logic [NoMstPorts-1:0] domain_mask_t;

   ccu_snoop_fanout_state_e state_q, state_d;
   snoop_ac_t               ac_q, ac_d;
   domain_mask_t            mask_q, mask_d;
   domain_mask_t            ac_done_q, ac_done_d;
   domain_mask_t            cr_done_q, cr_done_d;
   domain_mask_t            cd_done_q, cd_done_d;
   domain_mask_t            dt_q, dt_d;
   snoop_cr_t               resp_q, resp_d;
   logic [IdxW-1:0]         src_q, src_d;

   snoop_req_t                   slv_req;
   snoop_resp_t                  slv_resp;
   domain_mask_t                 slv_mask;
   snoop_req_t  [NoMstPorts-1:0] mst_reqs;
   snoop_resp_t [NoMstPorts-1:0] mst_resps;

   assign slv_req            = snp.slv_snoop_req;
   assign slv_mask           = snp.slv_mask;
   assign mst_resps          = snp.mst_snoop_resps;
   assign snp.slv_snoop_resp = slv_resp;
   assign snp.mst_snoop_reqs = mst_reqs;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ac_q      <= '0;
         mask_q    <= '0;
         ac_done_q <= '0;
         cr_done_q <= '0;
         cd_done_q <= '0;
         dt_q      <= '0;
         resp_q    <= '0;
         src_q     <= '0;
      end else begin
         state_q   <= state_d;
         ac_q      <= ac_d;
         mask_q    <= mask_d;
         ac_done_q <= ac_done_d;
         cr_done_q <= cr_done_d;
         cd_done_q <= cd_done_d;
         dt_q      <= dt_d;
         resp_q    <= resp_d;
         src_q     <= src_d;
      end
   end

   // Next state and outputs
   always_comb begin
      state_d   = state_q;
      ac_d      = ac_q;
      mask_d    = mask_q;
      ac_done_d = ac_done_q;
      cr_done_d = cr_done_q;
      cd_done_d = cd_done_q;
      dt_d      = dt_q;
      resp_d    = resp_q;
      src_d     = src_q;
      slv_resp  = '0;
      mst_reqs  = '0;

      // The registered AC sits on every port for the whole snoop so it is
      // stable from valid until each port's handshake.
      for (int i = 0; i < int'(NoMstPorts); i++) begin
         mst_reqs[i].ac = ac_q;
      end

      unique case (state_q)
         IDLE: begin
            slv_resp.ac_ready = 1'b1;
            if (slv_req.ac_valid) begin
               ac_d      = slv_req.ac;
               mask_d    = slv_mask;
               ac_done_d = '0;
               cr_done_d = '0;
               cd_done_d = '0;
               dt_d      = '0;
               resp_d    = '0;
               src_d     = '0;
               // An empty domain is answered directly with an all-zero CR.
               state_d   = (slv_mask == '0) ? RESP : SNOOP;
            end
         end

         SNOOP: begin
            for (int i = 0; i < int'(NoMstPorts); i++) begin
               mst_reqs[i].ac_valid = mask_q[i] & ~ac_done_q[i];
               mst_reqs[i].cr_ready = mask_q[i] & ac_done_q[i] & ~cr_done_q[i];
               if (mst_reqs[i].ac_valid && mst_resps[i].ac_ready) begin
                  ac_done_d[i] = 1'b1;
               end
               if (mst_reqs[i].cr_ready && mst_resps[i].cr_valid) begin
                  cr_done_d[i] = 1'b1;
                  resp_d       = resp_d | mst_resps[i].cr_resp;
                  dt_d[i]      = mst_resps[i].cr_resp[CrDataTransfer];
               end
            end
            // Compare with the done set including this cycle's handshakes so
            // the upstream CR follows the last downstream CR by one cycle.
            if (cr_done_d == mask_q) begin
               state_d = RESP;
            end
         end

         RESP: begin
            slv_resp.cr_valid = 1'b1;
            slv_resp.cr_resp  = resp_q;
            // Lowest-index data-transfer responder becomes the forwarded stream.
            src_d = IdxW'(lowest_set(32'(dt_q)));
            if (slv_req.cr_ready) begin
               state_d = resp_q[CrDataTransfer] ? DATA : IDLE;
            end
         end

         DATA: begin
            for (int i = 0; i < int'(NoMstPorts); i++) begin
               if (dt_q[i] && !cd_done_q[i]) begin
                  if (IdxW'(i) == src_q) begin
                     slv_resp.cd_valid    = mst_resps[i].cd_valid;
                     slv_resp.cd          = mst_resps[i].cd;
                     mst_reqs[i].cd_ready = slv_req.cd_ready;
                  end else begin
                     // Redundant data from other holders is accepted and dropped.
                     mst_reqs[i].cd_ready = 1'b1;
                  end
                  if (mst_reqs[i].cd_ready && mst_resps[i].cd_valid &&
                      mst_resps[i].cd.last) begin
                     cd_done_d[i] = 1'b1;
                  end
               end
            end
            if (cd_done_d == dt_q) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
module tb_ccu_snoop_fanout;
   import ccu_snoop_fanout_pkg::*;

   localparam int NP = 2;

   logic clk;
   logic rst_n;

   ccu_snoop_fanout_if #(.NoMstPorts(NP)) snp ();

   ccu_snoop_fanout #(.NoMstPorts(NP)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .snp   (snp.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   // ---------------- cache models and event capture ----------------
   int          phase [NP];   // 0 idle, 1 CR pending, 2 sending CD
   int          beat  [NP];
   logic [4:0]  crv   [NP];
   int          nb    [NP];
   bit          ac_rdy_en [NP];
   logic [63:0] base  [NP];

   bit          ac_hs [NP];
   bit          cr_hs [NP];
   bit          cd_hs [NP];
   int          ac_cnt  [NP];
   int          ac_cyc  [NP];
   logic [31:0] ac_addr [NP];
   int          cd_acc  [NP];

   int          cyc = 0;
   int          up_ac_cnt, up_ac_cyc, up_cr_cnt, up_cr_cyc;
   logic [4:0]  up_cr_resp;
   logic [63:0] beat_data [$];
   bit          beat_last [$];
   int          beat_cyc  [$];

   // Handshakes are sampled on the rising edge, before the DUT state moves.
   initial begin
      forever begin
         @(posedge clk);
         for (int p = 0; p < NP; p++) begin
            ac_hs[p] = snp.mst_snoop_reqs[p].ac_valid && snp.mst_snoop_resps[p].ac_ready;
            cr_hs[p] = snp.mst_snoop_reqs[p].cr_ready && snp.mst_snoop_resps[p].cr_valid;
            cd_hs[p] = snp.mst_snoop_reqs[p].cd_ready && snp.mst_snoop_resps[p].cd_valid;
            if (ac_hs[p]) begin
               ac_cnt[p]++;
               ac_cyc[p]  = cyc;
               ac_addr[p] = snp.mst_snoop_reqs[p].ac.addr;
            end
            if (cd_hs[p]) cd_acc[p]++;
         end
         if (snp.slv_snoop_req.ac_valid && snp.slv_snoop_resp.ac_ready) begin
            up_ac_cnt++;
            up_ac_cyc = cyc;
         end
         if (snp.slv_snoop_resp.cr_valid && snp.slv_snoop_req.cr_ready) begin
            up_cr_cnt++;
            up_cr_cyc  = cyc;
            up_cr_resp = snp.slv_snoop_resp.cr_resp;
         end
         if (snp.slv_snoop_resp.cd_valid && snp.slv_snoop_req.cd_ready) begin
            beat_data.push_back(snp.slv_snoop_resp.cd.data);
            beat_last.push_back(snp.slv_snoop_resp.cd.last);
            beat_cyc.push_back(cyc);
         end
         cyc++;
      end
   end

   // Cache responders: update on the falling edge from the captured handshakes.
   initial begin
      for (int p = 0; p < NP; p++) begin
         phase[p] = 0;
         beat[p]  = 0;
         snp.mst_snoop_resps[p] = '0;
      end
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            if (!rst_n) begin
               phase[p] = 0;
               beat[p]  = 0;
            end else begin
               if (ac_hs[p]) phase[p] = 1;
               if (cr_hs[p]) begin
                  phase[p] = crv[p][0] ? 2 : 0;
                  beat[p]  = 0;
               end
               if (cd_hs[p]) begin
                  if (beat[p] == nb[p] - 1) phase[p] = 0;
                  else beat[p]++;
               end
            end
            ac_hs[p] = 1'b0;
            cr_hs[p] = 1'b0;
            cd_hs[p] = 1'b0;
            snp.mst_snoop_resps[p].ac_ready = (phase[p] == 0) && ac_rdy_en[p];
            snp.mst_snoop_resps[p].cr_valid = (phase[p] == 1);
            snp.mst_snoop_resps[p].cr_resp  = crv[p];
            snp.mst_snoop_resps[p].cd_valid = (phase[p] == 2);
            snp.mst_snoop_resps[p].cd.data  = base[p] + 64'(beat[p]);
            snp.mst_snoop_resps[p].cd.last  = (beat[p] == nb[p] - 1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run_snoop(input logic [1:0] mask, input logic [31:0] addr);
      @(negedge clk);
      #2;
      up_ac_cnt = 0;
      up_cr_cnt = 0;
      up_ac_cyc = 0;
      up_cr_cyc = 0;
      up_cr_resp = '0;
      beat_data.delete();
      beat_last.delete();
      beat_cyc.delete();
      for (int p = 0; p < NP; p++) begin
         ac_cnt[p]  = 0;
         ac_cyc[p]  = 0;
         ac_addr[p] = '0;
         cd_acc[p]  = 0;
      end
      snp.slv_snoop_req.ac_valid   = 1'b1;
      snp.slv_snoop_req.ac.addr    = addr;
      snp.slv_snoop_req.ac.snoop   = 4'h1;
      snp.slv_snoop_req.ac.prot    = 3'h0;
      snp.slv_mask                 = mask;
      @(negedge clk);
      #2;
      snp.slv_snoop_req.ac_valid = 1'b0;
      snp.slv_mask               = '0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(up_cr_cnt >= 1 && snp.slv_snoop_resp.ac_ready) && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk({name, " completes"}, 64'(n < 200), 64'd1);
   endtask

   task automatic set_cfg(input logic [4:0] c0, input logic [4:0] c1, input int n0, input int n1);
      @(negedge clk);
      #2;
      crv[0] = c0;
      crv[1] = c1;
      nb[0]  = n0;
      nb[1]  = n1;
      ac_rdy_en[0] = 1'b1;
      ac_rdy_en[1] = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] mask;
      logic [4:0] cr0;
      logic [4:0] cr1;
      int         nb0;
      int         nb1;
      logic [4:0] exp_cr;
      int         exp_lat;    // upstream CR cycle minus upstream AC cycle
      int         exp_beats;  // beats forwarded upstream
      int         exp_src;    // port whose data is forwarded
      int         exp_ac0;
      int         exp_ac1;
      int         exp_drn0;   // CD beats accepted on port 0
      int         exp_drn1;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   initial begin
      //          mask   cr0    cr1    nb0 nb1 exp_cr lat bts src ac0 ac1 d0 d1
      vecs[0] = '{2'b00, 5'h00, 5'h00, 0,  0,  5'h00, 1,  0,  0,  0,  0,  0, 0};
      vecs[1] = '{2'b11, 5'h00, 5'h08, 0,  0,  5'h08, 3,  0,  0,  1,  1,  0, 0};
      vecs[2] = '{2'b11, 5'h00, 5'h05, 0,  4,  5'h05, 3,  4,  1,  1,  1,  0, 4};
      vecs[3] = '{2'b11, 5'h01, 5'h01, 2,  2,  5'h01, 3,  2,  0,  1,  1,  2, 2};
      vecs[4] = '{2'b01, 5'h02, 5'h00, 0,  0,  5'h02, 3,  0,  0,  1,  0,  0, 0};
      vecs[5] = '{2'b10, 5'h00, 5'h1C, 0,  0,  5'h1C, 3,  0,  0,  0,  1,  0, 0};
      vecs[6] = '{2'b11, 5'h03, 5'h04, 1,  0,  5'h07, 3,  1,  0,  1,  1,  1, 0};
      vecs[7] = '{2'b11, 5'h04, 5'h04, 0,  0,  5'h04, 3,  0,  0,  1,  1,  0, 0};

      base[0] = 64'hB0;
      base[1] = 64'hA0;
      for (int p = 0; p < NP; p++) begin
         crv[p] = '0;
         nb[p]  = 0;
         ac_rdy_en[p] = 1'b1;
         ac_hs[p] = 1'b0;
         cr_hs[p] = 1'b0;
         cd_hs[p] = 1'b0;
         ac_cnt[p] = 0;
         cd_acc[p] = 0;
      end
      up_ac_cnt = 0;
      up_cr_cnt = 0;
      snp.slv_snoop_req          = '0;
      snp.slv_snoop_req.cr_ready = 1'b1;
      snp.slv_snoop_req.cd_ready = 1'b1;
      snp.slv_mask               = '0;

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst ac_ready", 64'(snp.slv_snoop_resp.ac_ready), 64'd1);
      chk("rst cr_valid", 64'(snp.slv_snoop_resp.cr_valid), 64'd0);
      chk("rst cd_valid", 64'(snp.slv_snoop_resp.cd_valid), 64'd0);
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rst p%0d valid/ready", p),
             64'({snp.mst_snoop_reqs[p].ac_valid, snp.mst_snoop_reqs[p].cr_ready,
                  snp.mst_snoop_reqs[p].cd_ready}), 64'd0);
      end
      #1;
      rst_n = 1'b1;

      // ---------------- table-driven snoops ----------------
      for (int v = 0; v < NV; v++) begin
         logic [31:0] addr;
         int          nbt;
         addr = 32'h1000 + 32'(v * 16);
         set_cfg(vecs[v].cr0, vecs[v].cr1, vecs[v].nb0, vecs[v].nb1);
         run_snoop(vecs[v].mask, addr);
         wait_done($sformatf("v%0d", v));
         chk($sformatf("v%0d up_ac_cnt", v), 64'(up_ac_cnt), 64'd1);
         chk($sformatf("v%0d up_cr_cnt", v), 64'(up_cr_cnt), 64'd1);
         chk($sformatf("v%0d cr_resp", v), 64'(up_cr_resp), 64'(vecs[v].exp_cr));
         chk($sformatf("v%0d cr_lat", v), 64'(up_cr_cyc - up_ac_cyc), 64'(vecs[v].exp_lat));
         chk($sformatf("v%0d p0 ac_cnt", v), 64'(ac_cnt[0]), 64'(vecs[v].exp_ac0));
         chk($sformatf("v%0d p1 ac_cnt", v), 64'(ac_cnt[1]), 64'(vecs[v].exp_ac1));
         for (int p = 0; p < NP; p++) begin
            if (ac_cnt[p] == 1) begin
               chk($sformatf("v%0d p%0d ac_lat", v, p), 64'(ac_cyc[p] - up_ac_cyc), 64'd1);
               chk($sformatf("v%0d p%0d ac_addr", v, p), 64'(ac_addr[p]), 64'(addr));
            end
         end
         chk($sformatf("v%0d p0 cd_acc", v), 64'(cd_acc[0]), 64'(vecs[v].exp_drn0));
         chk($sformatf("v%0d p1 cd_acc", v), 64'(cd_acc[1]), 64'(vecs[v].exp_drn1));
         chk($sformatf("v%0d beats", v), 64'(beat_data.size()), 64'(vecs[v].exp_beats));
         nbt = (beat_data.size() < vecs[v].exp_beats) ? beat_data.size() : vecs[v].exp_beats;
         for (int b = 0; b < nbt; b++) begin
            chk($sformatf("v%0d b%0d data", v, b), beat_data[b],
                base[vecs[v].exp_src] + 64'(b));
            chk($sformatf("v%0d b%0d last", v, b), 64'(beat_last[b]),
                64'(b == vecs[v].exp_beats - 1));
            chk($sformatf("v%0d b%0d cyc", v, b), 64'(beat_cyc[b] - up_ac_cyc), 64'(4 + b));
         end
      end

      // ---------------- port 0 AC stalled for 10 cycles ----------------
      set_cfg(5'h00, 5'h00, 0, 0);
      ac_rdy_en[0] = 1'b0;
      run_snoop(2'b11, 32'h2000);
      repeat (10) @(negedge clk);
      #2;
      chk("stall no cr yet", 64'(up_cr_cnt), 64'd0);
      chk("stall p1 ac_cnt", 64'(ac_cnt[1]), 64'd1);
      chk("stall p0 ac_cnt", 64'(ac_cnt[0]), 64'd0);
      ac_rdy_en[0] = 1'b1;
      wait_done("stall");
      chk("stall p0 ac_cnt end", 64'(ac_cnt[0]), 64'd1);
      chk("stall p1 ac_cnt end", 64'(ac_cnt[1]), 64'd1);
      chk("stall cr after p0", 64'(up_cr_cyc - ac_cyc[0]), 64'd2);
      chk("stall cr_resp", 64'(up_cr_resp), 64'h00);

      // ---------------- reset in the middle of a CD stream ----------------
      set_cfg(5'h00, 5'h01, 0, 4);
      run_snoop(2'b10, 32'h3000);
      begin
         int n;
         n = 0;
         while (beat_data.size() < 1 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
         end
         chk("mid reset reaches data", 64'(n < 50), 64'd1);
      end
      chk("mid reset beats before", 64'(beat_data.size()), 64'd1);
      if (beat_data.size() >= 1) chk("mid reset beat0", beat_data[0], 64'hA0);
      rst_n = 1'b0;
      #1;
      chk("mid reset cd_valid", 64'(snp.slv_snoop_resp.cd_valid), 64'd0);
      chk("mid reset cr_valid", 64'(snp.slv_snoop_resp.cr_valid), 64'd0);
      chk("mid reset ac_ready", 64'(snp.slv_snoop_resp.ac_ready), 64'd1);
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("mid reset p%0d valid/ready", p),
             64'({snp.mst_snoop_reqs[p].ac_valid, snp.mst_snoop_reqs[p].cr_ready,
                  snp.mst_snoop_reqs[p].cd_ready}), 64'd0);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      chk("mid reset no extra beats", 64'(beat_data.size()), 64'd1);

      set_cfg(5'h08, 5'h00, 0, 0);
      run_snoop(2'b11, 32'h4000);
      wait_done("post reset");
      chk("post reset cr_resp", 64'(up_cr_resp), 64'h08);
      chk("post reset cr_lat", 64'(up_cr_cyc - up_ac_cyc), 64'd3);
      chk("post reset p0 ac_cnt", 64'(ac_cnt[0]), 64'd1);
      chk("post reset p1 ac_cnt", 64'(ac_cnt[1]), 64'd1);
      chk("post reset beats", 64'(beat_data.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
